write_buffer_ctl: RTL

Store write-buffer controller for the MEM stage. Buffers retired stores in a small FIFO and drains them into the D-cache when the cache port is free. Answers same-cycle load lookups by forwarding the youngest matching buffered store. Drives the `take_write_buffer` select and the forwarded data/ID consumed by the MEM-stage glue.

---
 rtl/mips_core_pkg.sv | 24 ++
 rtl/write_buffer_fifo.sv | 106 ++++++++++
 rtl/write_buffer_ctl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mips_core_pkg.sv
// Shared MEM-stage types for the store write buffer: entry record, controller
// state encoding and default sizing.
package mips_core_pkg;

    localparam int WB_DEPTH      = 4;
    localparam int WB_ADDR_WIDTH = 26;
    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_ID_WIDTH   = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } wb_state_t;

    // Field widths match the core's address/data/id widths.
    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
        logic [WB_ID_WIDTH-1:0]   id;
        logic                     valid;
    } wb_entry_t;

endpackage

// File: rtl/write_buffer_fifo.sv
// Write-buffer storage: circular FIFO of store entries with occupancy count
// and a youngest-first address match used for load forwarding.
module write_buffer_fifo
    import mips_core_pkg::*;
#(
    parameter int DEPTH      = WB_DEPTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ID_WIDTH   = WB_ID_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [ADDR_WIDTH-1:0]        push_addr_i,
    input  logic [DATA_WIDTH-1:0]        push_data_i,
    input  logic [ID_WIDTH-1:0]          push_id_i,
    input  logic                         pop_i,
    input  logic [ADDR_WIDTH-1:0]        lookup_addr_i,
    output logic [ADDR_WIDTH-1:0]        head_addr_o,
    output logic [DATA_WIDTH-1:0]        head_data_o,
    output logic [ID_WIDTH-1:0]          head_id_o,
    output logic                         hit_o,
    output logic [DATA_WIDTH-1:0]        hit_data_o,
    output logic [ID_WIDTH-1:0]          hit_id_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t        entries_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] match;
    logic [PW-1:0]    hit_idx;
    logic [PW-1:0]    scan_idx;

    assign head_d = pop_i  ? head_q + PW'(1) : head_q;
    assign tail_d = push_i ? tail_q + PW'(1) : tail_q;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // The controller never pushes into a full buffer, so head and tail never
    // collide on a simultaneous push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            if (pop_i) begin
                entries_q[head_q].valid <= 1'b0;
            end
            if (push_i) begin
                entries_q[tail_q] <= '{addr: push_addr_i, data: push_data_i,
                                       id: push_id_i, valid: 1'b1};
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign match[gi] = entries_q[gi].valid && (entries_q[gi].addr == lookup_addr_i);
    end

    // Walk from oldest (head) to youngest; a later match overrides an earlier one.
    always_comb begin
        hit_o    = 1'b0;
        hit_idx  = head_q;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + PW'(k);
            if (match[scan_idx]) begin
                hit_o   = 1'b1;
                hit_idx = scan_idx;
            end
        end
    end

    assign hit_data_o  = entries_q[hit_idx].data;
    assign hit_id_o    = entries_q[hit_idx].id;
    assign head_addr_o = entries_q[head_q].addr;
    assign head_data_o = entries_q[head_q].data;
    assign head_id_o   = entries_q[head_q].id;
    assign count_o     = count_q;

endmodule

// File: rtl/write_buffer_ctl.sv
// MEM-stage store write-buffer controller: drain FSM, load/drain arbitration
// and forwarding. Define MIPS_WB_FORWARD_EN to forward hits instead of stalling.
module write_buffer_ctl
    import mips_core_pkg::*;
#(
    parameter int DEPTH      = WB_DEPTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ID_WIDTH   = WB_ID_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    input  logic                         req_is_store,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic [DATA_WIDTH-1:0]        req_data,
    input  logic [ID_WIDTH-1:0]          req_id,
    output logic                         req_ready,
    input  logic                         drain_all,
    output logic                         dc_wr_valid,
    output logic [ADDR_WIDTH-1:0]        dc_wr_addr,
    output logic [DATA_WIDTH-1:0]        dc_wr_data,
    output logic [ID_WIDTH-1:0]          dc_wr_id,
    input  logic                         dc_wr_ready,
    output logic                         take_write_buffer,
    output logic [DATA_WIDTH-1:0]        fwd_data,
    output logic [ID_WIDTH-1:0]          fwd_id,
    output logic                         load_block,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int              CW         = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

    wb_state_t              state_q, state_d;
    logic                   load_req, store_ok, push, pop;
    logic                   count_nz, full, load_hit, drain_on_hit;
    logic                   fifo_hit;
    logic [CW-1:0]          occupancy;
    logic [ADDR_WIDTH-1:0]  head_addr;
    logic [DATA_WIDTH-1:0]  head_data, hit_data;
    logic [ID_WIDTH-1:0]    head_id, hit_id;

    write_buffer_fifo #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push_i        (push),
        .push_addr_i   (req_addr),
        .push_data_i   (req_data),
        .push_id_i     (req_id),
        .pop_i         (pop),
        .lookup_addr_i (req_addr),
        .head_addr_o   (head_addr),
        .head_data_o   (head_data),
        .head_id_o     (head_id),
        .hit_o         (fifo_hit),
        .hit_data_o    (hit_data),
        .hit_id_o      (hit_id),
        .count_o       (occupancy)
    );

    assign load_req = req_valid & ~req_is_store;
    assign count_nz = (occupancy != '0);
    assign full     = (occupancy == FULL_COUNT);
    assign store_ok = (occupancy < FULL_COUNT) & (state_q != FLUSH);
    assign push     = req_valid & req_is_store & store_ok;
    assign load_hit = load_req & fifo_hit;

    // Loads never wait on buffer space, so ready is only withheld from stores.
    assign req_ready = load_req | store_ok;

    assign dc_wr_valid = (state_q == DRAIN) | ((state_q == FLUSH) & count_nz);
    assign pop         = dc_wr_valid & dc_wr_ready;
    assign dc_wr_addr  = dc_wr_valid ? head_addr : '0;
    assign dc_wr_data  = dc_wr_valid ? head_data : '0;
    assign dc_wr_id    = dc_wr_valid ? head_id   : '0;

`ifdef MIPS_WB_FORWARD_EN
    assign take_write_buffer = load_hit;
    assign fwd_data          = load_hit ? hit_data : '0;
    assign fwd_id            = load_hit ? hit_id   : '0;
    assign load_block        = 1'b0;
    assign drain_on_hit      = 1'b0;
`else
    // Without forwarding a hitting load stalls and forces the buffer to drain.
    logic unused_fwd;
    assign unused_fwd        = ^{hit_data, hit_id};
    assign take_write_buffer = 1'b0;
    assign fwd_data          = '0;
    assign fwd_id            = '0;
    assign load_block        = load_hit;
    assign drain_on_hit      = load_hit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (drain_all) begin
                    state_d = FLUSH;
                end else if (count_nz && (!load_req || full || drain_on_hit)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_all) begin
                    state_d = FLUSH;
                end else if (pop) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (!count_nz || (pop && occupancy == CW'(1))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign empty = ~count_nz & (state_q == IDLE);
    assign count = occupancy;

endmodule
